// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared types and constants for the mux scan sequencer.
//   state_t        FSM state encoding (idle, settling on a channel, result held)
//   CH_W / NCH     channel select width and channel count of the 8:1 mux
//   CNT_W          settle counter width
//   SETTLE_MIN/MAX legal range of the per-channel settle time
//   settle_reload  counter reload value for a given settle time, clamped to range
package mux_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int CH_W       = 3;
  localparam int NCH        = 8;
  localparam int CNT_W      = 4;
  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;

  // An out-of-range settle time is pulled to the nearest legal value so the
  // 4-bit counter can never be loaded with a wrapped reload.
  function automatic logic [CNT_W-1:0] settle_reload(input int settle);
    int clamped;
    clamped = settle;
    if (clamped < SETTLE_MIN) clamped = SETTLE_MIN;
    if (clamped > SETTLE_MAX) clamped = SETTLE_MAX;
    return CNT_W'(clamped - 1);
  endfunction

endpackage

// File: rtl/mux_scan_next.sv
// mux_scan_next: combinational finder for the lowest enabled channel strictly
// above cur.
//   mask  [7:0] in   channel enables
//   cur   [2:0] in   current channel
//   nxt   [2:0] out  lowest enabled channel above cur (0 when none)
//   found       out  an enabled channel above cur exists
// Callers wanting the first channel overall check mask[0] themselves and use
// cur=0 for the rest, which treats cur as "below channel 0".
module mux_scan_next
  import mux_scan_pkg::*;
(
  input  logic [NCH-1:0]  mask,
  input  logic [CH_W-1:0] cur,
  output logic [CH_W-1:0] nxt,
  output logic            found
);

  always_comb begin
    nxt   = '0;
    found = 1'b0;
    // Walk downward so the last hit is the lowest qualifying channel.
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        nxt   = CH_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: drives the 8:1 mux select, waits SETTLE cycles per
// enabled channel, samples the mux output and returns an 8-bit snapshot.
// Parameter SETTLE (1..15, default 2): cycles between select change and sample.
// Ports:
//   clk, rst   clock; synchronous active-high reset
//   start      begin a scan (only looked at in idle)
//   mask[7:0]  channel enables, latched when a scan begins
//   s[2:0]     select to the mux;  y  mux output
//   data[7:0]  snapshot (disabled channels read 0)
//   valid/ready  result handshake
//   busy       high while settling or holding a result
//   dbg_state  current FSM state
// Handshake: data is offered while valid=1 and held stable until an edge where
// valid and ready are both high; ready may already be high before valid rises.
// Build option MUX_SCAN_CONT_EN: after each handshake a new scan starts from
// the live mask without start; with mask=0 the block idles until mask!=0.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [NCH-1:0]  mask,
  output logic [CH_W-1:0] s,
  input  logic            y,
  output logic [NCH-1:0]  data,
  output logic            valid,
  input  logic            ready,
  output logic            busy,
  output state_t          dbg_state
);

  localparam logic [CNT_W-1:0] CNT_RELOAD = settle_reload(SETTLE);

  state_t           state_q, state_d;
  logic [CH_W-1:0]  s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]   mask_q, mask_d;
  logic [NCH-1:0]   shadow_q, shadow_d;
  logic [NCH-1:0]   data_q, data_d;
  logic             valid_q, valid_d;
  logic             armed;
  logic             load_scan;

  logic [NCH-1:0]   find_mask;
  logic [CH_W-1:0]  find_cur;
  logic [CH_W-1:0]  find_nxt;
  logic             find_found;
  logic [CH_W-1:0]  first_ch;

`ifdef MUX_SCAN_CONT_EN
  // Set by the first handshake; from then on idle resumes on mask alone.
  logic cont_q, cont_d;
  assign armed = cont_q;
`else
  assign armed = 1'b0;
`endif

  // While settling the finder steps through the latched mask; elsewhere it
  // looks at the live mask to pick the first channel of a new scan.
  assign find_mask = (state_q == ST_SETTLE) ? mask_q : mask;
  assign find_cur  = (state_q == ST_SETTLE) ? s_q : '0;
  assign first_ch  = mask[0] ? '0 : find_nxt;

  mux_scan_next u_next (
    .mask  (find_mask),
    .cur   (find_cur),
    .nxt   (find_nxt),
    .found (find_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      s_q      <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
`ifdef MUX_SCAN_CONT_EN
      cont_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
`ifdef MUX_SCAN_CONT_EN
      cont_q   <= cont_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    shadow_d  = shadow_q;
    data_d    = data_q;
    valid_d   = valid_q;
    load_scan = 1'b0;
`ifdef MUX_SCAN_CONT_EN
    cont_d    = cont_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        s_d = '0;
        if ((start || armed) && (mask != '0)) begin
          load_scan = 1'b1;
        end else if (start && !armed) begin
          // Empty mask: report an all-zero snapshot straight away.
          data_d  = '0;
          valid_d = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shadow_d[s_q] = y;
          if (find_found) begin
            s_d   = find_nxt;
            cnt_d = CNT_RELOAD;
          end else begin
            data_d  = shadow_d;
            valid_d = 1'b1;
            s_d     = '0;
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (valid_q && ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
`ifdef MUX_SCAN_CONT_EN
          cont_d = 1'b1;
          if (mask != '0) load_scan = 1'b1;
`endif
        end
      end

      default: begin
        state_d = ST_IDLE;
        s_d     = '0;
        valid_d = 1'b0;
      end
    endcase

    if (load_scan) begin
      mask_d   = mask;
      shadow_d = '0;
      s_d      = first_ch;
      cnt_d    = CNT_RELOAD;
      state_d  = ST_SETTLE;
    end
  end

  assign s         = s_q;
  assign data      = data_q;
  assign valid     = valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer (single-shot build, SETTLE=2): directed vector
// table, random scans against a behavioural model, hold/ignore-start, reset
// mid-scan and post-handshake idle checks.
module tb_mux_scan_sequencer;
  import mux_scan_pkg::*;

  localparam int ST = 2;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] mask;
  logic [2:0] s;
  logic       y;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       busy;
  state_t     dbg_state;
  logic [7:0] pat;

  always #5 clk = ~clk;

  // Mux model: output is bit s of the current pattern.
  assign y = pat[s];

  mux_scan_sequencer #(.SETTLE(ST)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mask      (mask),
    .s         (s),
    .y         (y),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete scan. Expected select sequence: each enabled channel in
  // ascending order, held for ST edges. During the scan mask and start are
  // scrambled to show they are ignored; hold>0 keeps ready low after valid.
  task automatic run_scan(input logic [7:0] m, input logic [7:0] p,
                          input logic [7:0] ed, input int lat, input int hold);
    logic [2:0] exp_q[$];
    exp_q = {};
    for (int c = 0; c < 8; c++)
      if (m[c]) for (int k = 0; k < ST; k++) exp_q.push_back(3'(c));
    pat   = p;
    mask  = m;
    start = 1'b1;
    ready = (hold == 0);
    step();  // start edge E0
    for (int e = 0; e < lat; e++) begin
      if (exp_q.size() == 0) begin
        chk("seq_len", 8'(e), 8'(lat));
        break;
      end
      chk("scan_s", 8'(s), 8'(exp_q.pop_front()));
      chk("scan_valid", 8'(valid), 8'h0);
      chk("scan_busy", 8'(busy), 8'h1);
      start = 1'($urandom_range(0, 1));
      mask  = 8'($urandom);
      step();
    end
    chk("done_valid", 8'(valid), 8'h1);
    chk("done_data", data, ed);
    chk("done_s", 8'(s), 8'h0);
    chk("done_busy", 8'(busy), 8'h1);
    for (int h = 0; h < hold; h++) begin
      start = 1'b1;
      mask  = 8'($urandom);
      step();
      chk("hold_valid", 8'(valid), 8'h1);
      chk("hold_data", data, ed);
    end
    ready = 1'b1;
    start = 1'b1;   // lands in DONE: must be ignored
    step();         // handshake edge
    start = 1'b0;
    chk("hs_valid", 8'(valid), 8'h0);
    chk("hs_busy", 8'(busy), 8'h0);
    chk("hs_s", 8'(s), 8'h0);
    chk("hs_data_kept", data, ed);
    step();
    chk("post_idle", 8'(busy), 8'h0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [7:0] m;
    logic [7:0] p;
    logic [7:0] exp_data;
    int         exp_lat;   // edges after E0 until valid
  } vec_t;

  vec_t vecs[7];

  initial begin
    bit found;
    logic [7:0] rm, rp;

    vecs[0] = '{8'hFF, 8'hA5, 8'hA5, 16};
    vecs[1] = '{8'h12, 8'hFF, 8'h12, 4};
    vecs[2] = '{8'h00, 8'hFF, 8'h00, 0};
    vecs[3] = '{8'h80, 8'hFF, 8'h80, 2};
    vecs[4] = '{8'h01, 8'h00, 8'h00, 2};
    vecs[5] = '{8'h81, 8'hC3, 8'h81, 4};
    vecs[6] = '{8'h5A, 8'h0F, 8'h0A, 8};

    rst = 1'b1; start = 1'b0; ready = 1'b0; mask = '0; pat = '0;
    step(); step(); step();
    rst = 1'b0;
    chk("rst_s", 8'(s), 8'h0);
    chk("rst_data", data, 8'h0);
    chk("rst_valid", 8'(valid), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    chk("rst_state", 8'(dbg_state), 8'(ST_IDLE));
    step();

    for (int i = 0; i < 7; i++)
      run_scan(vecs[i].m, vecs[i].p, vecs[i].exp_data, vecs[i].exp_lat, 0);

    // Random scans against the model: snapshot = mask & pattern,
    // latency = ST per enabled channel.
    for (int i = 0; i < 25; i++) begin
      rm = 8'($urandom);
      if (i % 8 == 0) rm = 8'h00;
      rp = 8'($urandom);
      run_scan(rm, rp, rm & rp, ST * $countones(rm), (i % 3 == 0) ? $urandom_range(1, 5) : 0);
    end

    // Consumer stalls for 10 cycles with start pulses during DONE.
    run_scan(8'h3C, 8'hFF, 8'h3C, 8, 10);

    // Reset while sitting on channel 3 of a full scan.
    pat = 8'h66; mask = 8'hFF; start = 1'b1; ready = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (s == 3'd3) found = 1'b1;
      else step();
    end
    chk("reach_ch3", 8'(found), 8'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_s", 8'(s), 8'h0);
    chk("mid_rst_valid", 8'(valid), 8'h0);
    chk("mid_rst_busy", 8'(busy), 8'h0);
    chk("mid_rst_data", data, 8'h0);
    step();
    run_scan(8'hFF, 8'h5A, 8'h5A, 16, 0);

    // Single-shot: nothing further happens without start.
    for (int i = 0; i < 20; i++) begin
      mask = 8'($urandom);
      step();
      chk("idle_busy", 8'(busy), 8'h0);
      chk("idle_valid", 8'(valid), 8'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
